// File: rtl/fifo_rd_burst.sv
// Burst reader for the async FIFO read port: pops fixed-length bursts into a 2-entry skid buffer.
// Define RD_BURST_TIMEOUT_EN to also flush residual data as a partial burst after TIMEOUT idle cycles.
module fifo_rd_burst #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic             i_rd_clk,
  input  logic             i_rd_rstn,
  input  logic             i_rd_empty,
  input  logic [DEPTH:0]   i_rd_depth,
  input  logic [WIDTH-1:0] i_rd_data,
  output logic             o_rd_en,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic [WIDTH-1:0] o_m_data,
  output logic             o_m_last,
  output logic             o_busy,
  output logic [DEPTH:0]   o_burst_len
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [DEPTH:0] BURST_LEN_W = (DEPTH+1)'(BURST_LEN);
  localparam logic [DEPTH:0] ONE_W       = {{DEPTH{1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [DEPTH:0] beat_q, beat_d;
  logic [DEPTH:0] len_q, len_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic           wr_ptr_q, wr_ptr_d;
  logic [WIDTH:0] skid_q [0:1];
  logic [WIDTH:0] skid_d [0:1];
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic             busy_q, busy_d;

  logic pop_s;
  logic last_pop_s;
  logic xfer_s;
  logic head_last_s;
  logic start_full_s;
  logic start_part_s;

`ifdef RD_BURST_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  logic [TW-1:0] timer_q, timer_d;
  logic          residual_s;

  // Idle-residual timer: counts while the FIFO holds a sub-burst amount of data.
  always_comb begin
    residual_s   = !i_rd_empty && (i_rd_depth != '0) && (i_rd_depth < BURST_LEN_W);
    start_part_s = (state_q == ST_IDLE) && residual_s && (timer_q == TIMER_MAX);
    timer_d      = timer_q;
    if (state_q != ST_IDLE) begin
      timer_d = '0;
    end else if (i_rd_empty || start_full_s || start_part_s) begin
      timer_d = '0;
    end else if (residual_s && (timer_q != TIMER_MAX)) begin
      timer_d = timer_q + TIMER_ONE;
    end else begin
      timer_d = timer_q;
    end
  end

  // Timer register.
  always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
    if (!i_rd_rstn) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  // Only full bursts are ever issued in this build.
  always_comb begin
    start_part_s = 1'b0;
  end
`endif

  // Pop, transfer and last-beat qualifiers.
  always_comb begin
    start_full_s = (state_q == ST_IDLE) && (i_rd_depth >= BURST_LEN_W);
    pop_s        = (state_q == ST_BURST) && !i_rd_empty && (cnt_q != 2'd2) && (beat_q < len_q);
    last_pop_s   = pop_s && ((beat_q + ONE_W) == len_q);
    xfer_s       = (cnt_q != 2'd0) && i_m_ready;
    head_last_s  = skid_q[rd_ptr_q][WIDTH];
  end

  assign o_rd_en = pop_s;

  // Burst FSM: next state, beat counter and burst length.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (start_full_s) begin
          len_d   = BURST_LEN_W;
          beat_d  = '0;
          state_d = ST_BURST;
        end else if (start_part_s) begin
          len_d   = i_rd_depth;
          beat_d  = '0;
          state_d = ST_BURST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (pop_s) begin
          beat_d = beat_q + ONE_W;
        end else begin
          beat_d = beat_q;
        end
        if (last_pop_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_BURST;
        end
      end
      ST_DRAIN: begin
        if (xfer_s && head_last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Skid buffer: ring of two {last, data} entries; push and pop may coincide.
  always_comb begin
    skid_d[0] = skid_q[0];
    skid_d[1] = skid_q[1];
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (pop_s) begin
      skid_d[wr_ptr_q] = {last_pop_s, i_rd_data};
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (xfer_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, pop_s} - {1'b0, xfer_s};
  end

  // Output stage presents the head entry of the next cycle from flops.
  always_comb begin
    m_valid_d = (cnt_d != 2'd0);
    m_data_d  = skid_d[rd_ptr_d][WIDTH-1:0];
    m_last_d  = skid_d[rd_ptr_d][WIDTH];
    busy_d    = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
    if (!i_rd_rstn) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      len_q     <= '0;
      cnt_q     <= 2'd0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      skid_q[0] <= '0;
      skid_q[1] <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      skid_q[0] <= skid_d[0];
      skid_q[1] <= skid_d[1];
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
    end
  end

  assign o_m_valid   = m_valid_q;
  assign o_m_data    = m_data_q;
  assign o_m_last    = m_last_q;
  assign o_busy      = busy_q;
  assign o_burst_len = len_q;

endmodule

// File: doc/fifo_rd_burst.md
Name: fifo_rd_burst

Overview:
Read-side consumer for the team's async FIFO, running entirely in the read clock domain. It watches the FIFO occupancy and pops data in fixed-length bursts from the first-word-fall-through read port. It presents each burst downstream as a valid/ready stream, with a last flag on the final beat. An internal 2-entry skid buffer decouples downstream backpressure from the FIFO pop.

Parameters:
WIDTH, 8, data width; must match the FIFO WIDTH.
DEPTH, 8, FIFO address bits (FIFO holds 2^DEPTH words); must match the FIFO DEPTH.
BURST_LEN, 16, beats per full burst; legal range 1..2^DEPTH.
TIMEOUT, 64, read-clock cycles a non-empty FIFO may sit below BURST_LEN before a partial burst is issued (used only with RD_BURST_TIMEOUT_EN); must be at least 1.

Ports:
i_rd_clk  in  1  read-domain clock
i_rd_rstn  in  1  asynchronous active-low reset
i_rd_empty  in  1  FIFO empty flag (registered in the FIFO)
i_rd_depth  in  DEPTH+1  FIFO occupancy, unsigned
i_rd_data  in  WIDTH  FIFO head word; valid whenever i_rd_empty is 0
o_rd_en  out  1  FIFO pop strobe
o_m_valid  out  1  output beat valid
i_m_ready  in  1  downstream accepts the beat
o_m_data  out  WIDTH  output beat data
o_m_last  out  1  final beat of the current burst
o_busy  out  1  asserted whenever the FSM is not in IDLE
o_burst_len  out  DEPTH+1  beat count of the current or most recent burst

Behaviour:
- Reset (asynchronous, active-low) clears everything:
  - o_rd_en=0, o_m_valid=0, o_m_data=0, o_m_last=0, o_busy=0, o_burst_len=0.
  - Skid buffer count=0, FSM state=IDLE, beat counter=0, timeout timer=0.
- FIFO pop rule:
  - o_rd_en = (state==BURST) && !i_rd_empty && (skid count<2) && (beats popped < target).
  - o_rd_en is combinational.
  - i_rd_data is captured into the skid buffer on the same clock edge as the pop.
- Skid buffer:
  - 2 entries; each entry stores {last, data}.
  - o_m_valid = (count!=0); o_m_data and o_m_last come from the head entry.
  - A beat transfers when o_m_valid && i_m_ready.
  - Simultaneous push and transfer leaves count unchanged and keeps order.
  - With count=1 and i_m_ready held at 1, throughput is 1 beat per cycle.
  - o_m_data and o_m_last must stay stable while o_m_valid=1 and i_m_ready=0.
- FSM:
  - IDLE: when i_rd_depth >= BURST_LEN, set target=BURST_LEN, load o_burst_len=BURST_LEN, clear the beat counter, and go to BURST next cycle.
  - BURST: the beat counter increments on every pop. The pop that makes the counter equal target is tagged last=1. That same cycle moves to DRAIN.
  - DRAIN: wait until the beat tagged last transfers downstream, then go to IDLE. No pops occur in DRAIN.
- Latency:
  - Burst start to first o_rd_en: 1 cycle after the IDLE condition is met.
  - Pop to o_m_valid: 1 cycle.
- i_rd_empty asserted mid-burst: popping stalls and the FSM stays in BURST. No timeout applies inside BURST.
- Arithmetic: the beat counter and o_burst_len are DEPTH+1 bits. BURST_LEN = 2^DEPTH is legal, so a full-FIFO burst must fit the counter.
- Pop safety: popping while i_rd_empty=1 is never allowed.
- Reset mid-burst: all state clears immediately. Beats held in the skid buffer are discarded.

Optional Feature:
RD_BURST_TIMEOUT_EN
- Defined (timeout enabled):
  - In IDLE, the timer counts each cycle that i_rd_empty=0 and i_rd_depth < BURST_LEN.
  - The timer clears to 0 when the FIFO is empty or a burst starts.
  - When the timer reaches TIMEOUT-1, set target=i_rd_depth (which is at least 1 and below BURST_LEN), load o_burst_len with it, and enter BURST.
  - The partial burst's final beat carries o_m_last=1.
- Not defined: no timer logic is present, and only full BURST_LEN bursts are issued; residual data below BURST_LEN stays in the FIFO.

Test Plan:
- BURST_LEN=4, FIFO preloaded with 0x10..0x13, i_m_ready=1 -> o_rd_en high 4 consecutive cycles; o_m_data 0x10,0x11,0x12,0x13 on consecutive cycles; o_m_last=1 only with 0x13; o_busy falls the cycle after 0x13 transfers.
- Depth 3 with BURST_LEN=4, macro undefined, held 200 cycles -> o_rd_en never asserts, o_busy=0.
- Same case with the macro defined and TIMEOUT=8 -> burst starts about 8 cycles after the FIFO goes non-empty; o_burst_len=3; last beat is the 3rd.
- Full burst with i_m_ready toggling 1,0,1,0 -> no beat lost or duplicated; data stable while stalled; skid count never exceeds 2; o_rd_en=0 while count=2.
- FIFO empties after 2 of 4 beats, refills 10 cycles later -> o_rd_en drops, FSM stays BURST, resumes, o_m_last on the 4th beat.
- i_rd_rstn pulsed low mid-burst -> all outputs 0 asynchronously; FSM returns to IDLE; the next burst starts cleanly with o_burst_len reloaded.
